dkong_dl_router: RTL and testbench
==================================

# dkong_dl_router

Download router and post-load reset sequencer between the HPS ioctl stream and the Donkey Kong core. It decodes each downloaded byte by index and address into write strobes for the main-CPU ROM, sound ROM, wave ROM and the `dkong_top` internal download port. It latches the DIP bytes (index 254) and the game-variant byte (index 1). It holds the game in reset during loading and for a fixed stretch afterwards, so the CPUs never start on a partial image.

## Interface

Parameters:
- `HOLD_CYCLES`, 16: clocks of game reset held after `I_DL_DOWNLOAD` falls (1..255).
- `ROM_END`, 17'h1FFFF: highest legal index-0 address; a write above it sets `O_ERR`.

Ports:
- `I_CLK_24576M`  in  1  system clock; all logic on rising edge.
- `I_RESETn`  in  1  synchronous, active-low reset.
- `I_DL_DOWNLOAD`  in  1  download in progress.
- `I_DL_WR`  in  1  single-cycle byte-valid strobe.
- `I_DL_ADDR`  in  25  byte address within current index.
- `I_DL_DATA`  in  8  byte value.
- `I_DL_INDEX`  in  8  0 = ROM image, 1 = variant byte, 254 = DIP bank.
- `O_DATA`  out  8  registered copy of `I_DL_DATA`, shared by all write ports.
- `O_MAIN_WE`  out  1  main ROM write strobe.
- `O_MAIN_A`  out  15  main ROM write address.
- `O_SND_WE`  out  1  sound ROM write strobe.
- `O_SND_A`  out  12  sound ROM write address.
- `O_WAV_WE`  out  1  wave ROM write strobe.
- `O_WAV_A`  out  16  wave ROM write address.
- `O_TOP_WE`  out  1  `dkong_top` DL_WR strobe.
- `O_TOP_A`  out  16  `dkong_top` DL_ADDR.
- `O_DIP_SW0`  out  8  DIP byte 0.
- `O_DIP_SW1`  out  8  DIP byte 1.
- `O_MOD`  out  5  one-hot variant: bit0 dk, bit1 dkjr, bit2 dk3, bit3 radarscope, bit4 pestplace.
- `O_GAME_RESET`  out  1  active-high reset to the core.
- `O_ROM_LEN`  out  17  count of accepted index-0 bytes in the last load (saturates at 17'h1FFFF).
- `O_ERR`  out  1  sticky: out-of-range ROM address or variant byte > 4.

## Operation

- FSM states: IDLE, LOAD, HOLD, RUN.
  - IDLE → LOAD when `I_DL_DOWNLOAD` = 1.
  - IDLE → HOLD otherwise, so power-up gets one reset stretch.
  - LOAD → HOLD on `I_DL_DOWNLOAD` falling.
  - HOLD → RUN after `HOLD_CYCLES` clocks.
  - HOLD or RUN → LOAD whenever `I_DL_DOWNLOAD` rises.
- `O_GAME_RESET` = 1 in IDLE, LOAD and HOLD; 0 only in RUN.
- Entering LOAD clears `O_ROM_LEN` and `O_ERR`.
- Index-0 writes (only while `I_DL_DOWNLOAD` = 1):
  - addr < 0x8000: `O_MAIN_WE`, `O_MAIN_A` = addr[14:0].
  - 0xE000 ≤ addr < 0xF000: `O_SND_WE`, `O_SND_A` = addr[11:0].
  - addr[24:16] = 1: `O_WAV_WE`, `O_WAV_A` = addr[15:0].
  - addr[24:16] = 0: `O_TOP_WE`, `O_TOP_A` = addr[15:0]. This fires in parallel with the main or sound strobe.
  - Every index-0 write increments `O_ROM_LEN`.
  - addr > `ROM_END`: no strobe, no count, `O_ERR` ← 1.
- Index-1 write at addr 0 latches the variant byte.
  - `O_MOD` = one-hot of the value.
  - A value > 4 gives `O_MOD` = 5'b00001 and sets `O_ERR`.
  - Writes at other addresses are ignored.
- Index-254 writes with addr[24:3] = 0 store into an 8-byte bank; bytes 0 and 1 are exposed. Index-254 writes do not require `I_DL_DOWNLOAD`.
- All other indices are ignored.
- Reset values:
  - All strobes 0.
  - Addresses, `O_DATA`, `O_DIP_SW0`, `O_DIP_SW1`, `O_ROM_LEN` = 0.
  - `O_MOD` = 5'b00001.
  - `O_ERR` = 0.
  - `O_GAME_RESET` = 1.
  - FSM = IDLE.

## Timing

- Write path latency is 1 clock.
  - Strobes, addresses and `O_DATA` are registered together.
  - Strobes are asserted exactly one cycle per `I_DL_WR` pulse.
- Back-to-back `I_DL_WR` on consecutive cycles: each byte is routed, no drops.
- `O_MOD`, `O_DIP_SW0` and `O_DIP_SW1` update 1 clock after the write. `O_MOD` never shows zero or multi-hot.
- `O_GAME_RESET` deasserts exactly `HOLD_CYCLES` + 1 clocks after the cycle in which `I_DL_DOWNLOAD` is first sampled low.
- `I_DL_WR` in the same cycle `I_DL_DOWNLOAD` falls: the byte is still routed (gating uses the same-cycle `I_DL_DOWNLOAD`).
- `I_RESETn` low mid-load: on the next edge, outputs return to reset values and FSM goes to IDLE. On release with `I_DL_DOWNLOAD` still 1, FSM enters LOAD on the first enabled edge.
- `I_DL_DOWNLOAD` rising during HOLD restarts at LOAD; the hold counter reloads on the next fall.

## Test plan

- Reset release with download low → `O_GAME_RESET` = 1 for 1 + 16 clocks, then 0; `O_MOD` = 5'b00001.
- Index 0: stream bytes at 0x0000, 0x7FFF, 0xE000, 0x10005 → one-cycle-late strobes:
  - 0x0000: MAIN_A = 0, TOP_A = 0.
  - 0x7FFF: MAIN_A = 0x7FFF, TOP_A = 0x7FFF.
  - 0xE000: SND_A = 0, TOP_A = 0xE000.
  - 0x10005: WAV_A = 5 only.
  - Result: `O_ROM_LEN` = 4.
- Write at addr 0x20000 in index 0 → no strobe, `O_ERR` = 1, `O_ROM_LEN` unchanged. A new download start clears `O_ERR`.
- Index 1, byte 0x04 → `O_MOD` = 5'b10000. Byte 0x07 → `O_MOD` = 5'b00001 and `O_ERR` = 1.
- Index 254, bytes 0xA5 at addr 0 and 0x3C at addr 1, download low → `O_DIP_SW0` = 0xA5, `O_DIP_SW1` = 0x3C. A write at addr 8 is ignored.
- `I_RESETn` pulsed low for 1 clock mid-stream with download held high → strobes drop the next cycle, FSM goes to LOAD after release, subsequent bytes route normally, `O_GAME_RESET` stays 1 throughout.

Source files
------------

// File: rtl/dkong_dl_router.sv
// Routes the HPS ioctl download stream into the Donkey Kong ROM write ports, latches DIP and
// variant bytes, and holds the core in reset while loading and for HOLD_CYCLES clocks after.
module dkong_dl_router #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter logic [16:0] ROM_END     = 17'h1FFFF
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESETn,
    input  logic        I_DL_DOWNLOAD,
    input  logic        I_DL_WR,
    input  logic [24:0] I_DL_ADDR,
    input  logic [7:0]  I_DL_DATA,
    input  logic [7:0]  I_DL_INDEX,
    output logic [7:0]  O_DATA,
    output logic        O_MAIN_WE,
    output logic [14:0] O_MAIN_A,
    output logic        O_SND_WE,
    output logic [11:0] O_SND_A,
    output logic        O_WAV_WE,
    output logic [15:0] O_WAV_A,
    output logic        O_TOP_WE,
    output logic [15:0] O_TOP_A,
    output logic [7:0]  O_DIP_SW0,
    output logic [7:0]  O_DIP_SW1,
    output logic [4:0]  O_MOD,
    output logic        O_GAME_RESET,
    output logic [16:0] O_ROM_LEN,
    output logic        O_ERR
);

    typedef enum logic [1:0] {StIdle, StLoad, StHold, StRun} state_e;

    localparam logic [7:0]  HoldLast = 8'(HOLD_CYCLES - 1);
    localparam logic [16:0] LenMax   = 17'h1FFFF;

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  dip_q [8];

    logic        load_entry;
    logic        wr_rom, rom_ok, rom_err;
    logic        main_hit, snd_hit, wav_hit, top_hit;
    logic        var_wr, var_bad, dip_wr;
    logic [16:0] rom_len_d;
    logic        err_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            StIdle: begin
                state_d    = I_DL_DOWNLOAD ? StLoad : StHold;
                hold_cnt_d = '0;
            end
            StLoad: begin
                if (!I_DL_DOWNLOAD) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end
            end
            StHold: begin
                if (I_DL_DOWNLOAD) begin
                    state_d = StLoad;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StRun: begin
                if (I_DL_DOWNLOAD) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // Write decode uses the same-cycle download level so a byte coincident with the fall lands.
    always_comb begin
        load_entry = I_DL_DOWNLOAD && (state_q != StLoad);
        wr_rom     = I_DL_WR && I_DL_DOWNLOAD && (I_DL_INDEX == 8'd0);
        rom_ok     = I_DL_ADDR <= {8'd0, ROM_END};
        rom_err    = wr_rom && !rom_ok;
        main_hit   = wr_rom && rom_ok && (I_DL_ADDR < 25'h0008000);
        snd_hit    = wr_rom && rom_ok && (I_DL_ADDR >= 25'h000E000) && (I_DL_ADDR < 25'h000F000);
        wav_hit    = wr_rom && rom_ok && (I_DL_ADDR[24:16] == 9'd1);
        top_hit    = wr_rom && rom_ok && (I_DL_ADDR[24:16] == 9'd0);
        var_wr     = I_DL_WR && I_DL_DOWNLOAD && (I_DL_INDEX == 8'd1) && (I_DL_ADDR == 25'd0);
        var_bad    = I_DL_DATA > 8'd4;
        dip_wr     = I_DL_WR && (I_DL_INDEX == 8'd254) && (I_DL_ADDR[24:3] == 22'd0);

        rom_len_d = load_entry ? 17'd0 : O_ROM_LEN;
        if (wr_rom && rom_ok && (rom_len_d != LenMax)) rom_len_d = rom_len_d + 17'd1;
        err_d = (load_entry ? 1'b0 : O_ERR) | rom_err | (var_wr && var_bad);
    end

    always_ff @(posedge I_CLK_24576M) begin
        if (!I_RESETn) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            O_DATA     <= '0;
            O_MAIN_WE  <= 1'b0;
            O_MAIN_A   <= '0;
            O_SND_WE   <= 1'b0;
            O_SND_A    <= '0;
            O_WAV_WE   <= 1'b0;
            O_WAV_A    <= '0;
            O_TOP_WE   <= 1'b0;
            O_TOP_A    <= '0;
            O_MOD      <= 5'b00001;
            O_ROM_LEN  <= '0;
            O_ERR      <= 1'b0;
            for (int i = 0; i < 8; i++) dip_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            O_DATA     <= I_DL_DATA;
            O_MAIN_WE  <= main_hit;
            O_SND_WE   <= snd_hit;
            O_WAV_WE   <= wav_hit;
            O_TOP_WE   <= top_hit;
            if (main_hit) O_MAIN_A <= I_DL_ADDR[14:0];
            if (snd_hit)  O_SND_A  <= I_DL_ADDR[11:0];
            if (wav_hit)  O_WAV_A  <= I_DL_ADDR[15:0];
            if (top_hit)  O_TOP_A  <= I_DL_ADDR[15:0];
            if (var_wr)   O_MOD    <= var_bad ? 5'b00001 : (5'b00001 << I_DL_DATA[2:0]);
            if (dip_wr)   dip_q[I_DL_ADDR[2:0]] <= I_DL_DATA;
            O_ROM_LEN  <= rom_len_d;
            O_ERR      <= err_d;
        end
    end

    assign O_DIP_SW0    = dip_q[0];
    assign O_DIP_SW1    = dip_q[1];
    assign O_GAME_RESET = (state_q != StRun);

endmodule

// File: tb/tb_dkong_dl_router.sv
// Randomized bench for dkong_dl_router against a cycle-level behavioural model of the router.
module tb_dkong_dl_router;

    localparam int H = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, dl = 1'b0, wr = 1'b0;
    logic [24:0] addr = '0;
    logic [7:0]  din = '0, idx = '0;

    logic [7:0]  o_data, o_dip0, o_dip1;
    logic        o_main_we, o_snd_we, o_wav_we, o_top_we, o_game_reset, o_err;
    logic [14:0] o_main_a;
    logic [11:0] o_snd_a;
    logic [15:0] o_wav_a, o_top_a;
    logic [4:0]  o_mod;
    logic [16:0] o_rom_len;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int          since;
    bit          in_load, m_rst;
    bit          m_main, m_snd, m_wav, m_top, m_err;
    int          m_main_a, m_snd_a, m_wav_a, m_top_a, m_len, m_mod, m_dip0, m_dip1, m_data;

    always #5 clk = ~clk;

    dkong_dl_router #(.HOLD_CYCLES(H), .ROM_END(17'h1FFFF)) dut (
        .I_CLK_24576M (clk),
        .I_RESETn     (rst_n),
        .I_DL_DOWNLOAD(dl),
        .I_DL_WR      (wr),
        .I_DL_ADDR    (addr),
        .I_DL_DATA    (din),
        .I_DL_INDEX   (idx),
        .O_DATA       (o_data),
        .O_MAIN_WE    (o_main_we),
        .O_MAIN_A     (o_main_a),
        .O_SND_WE     (o_snd_we),
        .O_SND_A      (o_snd_a),
        .O_WAV_WE     (o_wav_we),
        .O_WAV_A      (o_wav_a),
        .O_TOP_WE     (o_top_we),
        .O_TOP_A      (o_top_a),
        .O_DIP_SW0    (o_dip0),
        .O_DIP_SW1    (o_dip1),
        .O_MOD        (o_mod),
        .O_GAME_RESET (o_game_reset),
        .O_ROM_LEN    (o_rom_len),
        .O_ERR        (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Applies the rules to the inputs sampled at this edge.
    task automatic model_edge();
        int a;
        a = int'(addr);
        m_main = 0; m_snd = 0; m_wav = 0; m_top = 0;
        m_rst = !rst_n;
        if (!rst_n) begin
            since = 0; in_load = 0; m_err = 0; m_len = 0; m_mod = 1;
            m_dip0 = 0; m_dip1 = 0; m_data = 0;
            m_main_a = 0; m_snd_a = 0; m_wav_a = 0; m_top_a = 0;
        end else begin
            if (dl && !in_load) begin
                m_len = 0;
                m_err = 0;
            end
            if (wr && dl && idx == 8'd0) begin
                if (a > 32'h1FFFF) m_err = 1;
                else begin
                    if (m_len < 32'h1FFFF) m_len++;
                    if (a < 32'h8000) begin m_main = 1; m_main_a = a; end
                    if (a >= 32'hE000 && a < 32'hF000) begin m_snd = 1; m_snd_a = a - 32'hE000; end
                    if (a / 65536 == 1) begin m_wav = 1; m_wav_a = a - 65536; end
                    if (a / 65536 == 0) begin m_top = 1; m_top_a = a; end
                end
            end
            if (wr && dl && idx == 8'd1 && a == 0) begin
                if (din > 8'd4) begin m_mod = 1; m_err = 1; end
                else m_mod = 1 << din;
            end
            if (wr && idx == 8'd254 && a < 8) begin
                if (a == 0) m_dip0 = int'(din);
                if (a == 1) m_dip1 = int'(din);
            end
            since   = dl ? 0 : (since < 1000 ? since + 1 : since);
            in_load = dl;
            m_data  = int'(din);
        end
    endtask

    task automatic check_all();
        check("data", 32'(o_data), m_data);
        check("main_we", 32'(o_main_we), 32'(m_main));
        check("snd_we", 32'(o_snd_we), 32'(m_snd));
        check("wav_we", 32'(o_wav_we), 32'(m_wav));
        check("top_we", 32'(o_top_we), 32'(m_top));
        if (m_main || m_rst) check("main_a", 32'(o_main_a), m_main_a);
        if (m_snd || m_rst)  check("snd_a", 32'(o_snd_a), m_snd_a);
        if (m_wav || m_rst)  check("wav_a", 32'(o_wav_a), m_wav_a);
        if (m_top || m_rst)  check("top_a", 32'(o_top_a), m_top_a);
        check("dip0", 32'(o_dip0), m_dip0);
        check("dip1", 32'(o_dip1), m_dip1);
        check("mod", 32'(o_mod), m_mod);
        check("game_reset", 32'(o_game_reset), 32'(since < H + 1));
        check("rom_len", 32'(o_rom_len), m_len);
        check("err", 32'(o_err), 32'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic d, input logic w, input logic [24:0] a,
                         input logic [7:0] da, input logic [7:0] ix);
        rst_n = r; dl = d; wr = w; addr = a; din = da; idx = ix;
        cycle();
    endtask

    initial begin
        int pick;
        // Reset, then a power-up hold stretch with download low
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < H + 4; i++) drive(1, 0, 0, 0, 8'(i), 0);

        // ROM image routing, including an out-of-range address
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 25'h0000000, 8'h11, 0);
        drive(1, 1, 1, 25'h0007FFF, 8'h22, 0);
        drive(1, 1, 1, 25'h000E000, 8'h33, 0);
        drive(1, 1, 1, 25'h0010005, 8'h44, 0);
        drive(1, 1, 0, 0, 0, 0);
        check("rom_len_4", 32'(o_rom_len), 4);
        drive(1, 1, 1, 25'h0020000, 8'h55, 0);
        drive(1, 1, 0, 0, 0, 0);

        // Variant byte, good then bad
        drive(1, 1, 1, 0, 8'h04, 1);
        drive(1, 1, 0, 0, 0, 0);
        check("mod_dk_pest", 32'(o_mod), 32'h10);
        drive(1, 1, 1, 0, 8'h07, 1);
        drive(1, 1, 0, 0, 0, 0);

        // Download end with a coincident byte, then hold stretch
        drive(1, 0, 1, 25'h0000100, 8'h66, 0);
        for (int i = 0; i < H + 3; i++) drive(1, 0, 0, 0, 0, 0);

        // DIP bank with download low
        drive(1, 0, 1, 0, 8'hA5, 254);
        drive(1, 0, 1, 1, 8'h3C, 254);
        drive(1, 0, 1, 8, 8'hFF, 254);
        drive(1, 0, 0, 0, 0, 0);
        check("dip_a5", 32'(o_dip0), 32'hA5);

        // New download clears error; reset pulse mid-stream
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 25'(i * 3), 8'(i), 0);
        drive(0, 1, 1, 25'h10, 8'h77, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 25'h0E000 + 25'(i), 8'(i), 0);
        drive(1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) dl = !dl;
            wr = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 5));
            idx = (pick < 3) ? 8'd0 : (pick == 3) ? 8'd1 : (pick == 4) ? 8'd254 : 8'($urandom);
            case ($urandom_range(0, 5))
                0: addr = 25'($urandom_range(0, 32'h7FFF));
                1: addr = 25'($urandom_range(32'hE000, 32'hEFFF));
                2: addr = 25'($urandom_range(32'h8000, 32'hFFFF));
                3: addr = 25'($urandom_range(32'h10000, 32'h1FFFF));
                4: addr = 25'($urandom);
                default: addr = 25'($urandom_range(0, 15));
            endcase
            if (idx == 8'd1) begin
                addr = ($urandom_range(0, 3) == 0) ? 25'd1 : 25'd0;
                din  = 8'($urandom_range(0, 7));
            end else begin
                din = 8'($urandom);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
